// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the configuration-chain loader.
//
// Contents:
//   state_e  - loader FSM states
//   ceil_div - integer ceiling division, used to size word counts
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Number of host words needed to cover a chain of a_bits bits.
  function automatic int unsigned ceil_div(input int unsigned a_bits,
                                           input int unsigned b_width);
    return (a_bits + b_width - 1) / b_width;
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Phase-length timer for the programming-clock generator.
//
// A down-counter reloaded with CLK_DIV-1 whenever a new prog_clk phase
// begins; o_last is high in the final cycle of the phase.
//
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous active-high reset
//   i_load - a new phase starts on the next cycle
//   o_last - current cycle is the last one of the phase
module cfg_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_last
);

  localparam int DIVCNT_W = $clog2(CLK_DIV + 1);
  localparam logic [DIVCNT_W-1:0] RELOAD = DIVCNT_W'(CLK_DIV - 1);

  logic [DIVCNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader for the fabric programming chain.
//
// Takes host words over a valid/ready stream and shifts them LSB-first
// into the chain with a slow registered prog_clk (CLK_DIV clk cycles per
// half-period). The bit leaving the chain tail is sampled just before each
// rising prog_clk edge and returned as readback words.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   start               - pulse that begins a load (ignored while busy)
//   cfg_data/valid/ready- host configuration word stream
//   prog_in/clk/en      - chain head data, shift clock, shift enable
//   prog_out            - chain tail data
//   rb_data/rb_valid    - readback word and its one-cycle strobe
//   busy, done          - load in progress / last load completed
module config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 100,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int BITCNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WBIT_W   = $clog2(WORD_W);
  localparam logic [BITCNT_W-1:0] LAST_BIT  = BITCNT_W'(CHAIN_LEN - 1);
  localparam logic [WBIT_W-1:0]   LAST_WBIT = WBIT_W'(WORD_W - 1);

  state_e r_state;
  state_e w_next;

  logic [BITCNT_W-1:0] r_bitcnt;
  logic [WBIT_W-1:0]   r_wbit;
  logic [WORD_W-1:0]   r_buf;
  logic [WORD_W-1:0]   r_rb_buf;
  logic [WORD_W-1:0]   r_rb_data;
  logic                r_cfg_ready;
  logic                r_prog_clk;
  logic                r_prog_en;
  logic                r_rb_valid;
  logic                r_busy;
  logic                r_done;

  logic w_phase_last;
  logic w_phase_load;
  logic w_go;
  logic w_accept;
  logic w_sample;
  logic w_bit_end;
  logic w_last_bit;
  logic w_word_end;
  logic w_rb_emit;

  assign w_go       = (r_state == IDLE) && start;
  assign w_accept   = (r_state == FETCH) && cfg_valid;
  assign w_sample   = (r_state == SHIFT_LO) && w_phase_last;
  assign w_bit_end  = (r_state == SHIFT_HI) && w_phase_last;
  assign w_last_bit = (r_bitcnt == LAST_BIT);
  assign w_word_end = (r_wbit == LAST_WBIT);
  assign w_rb_emit  = w_bit_end && (w_last_bit || w_word_end);

  // Reload the phase timer whenever a low or high phase is entered fresh.
  assign w_phase_load = ((w_next == SHIFT_LO) || (w_next == SHIFT_HI)) &&
                        (w_next != r_state);

  cfg_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(w_phase_load),
    .o_last(w_phase_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = FETCH;
      FETCH:    if (cfg_valid) w_next = SHIFT_LO;
      SHIFT_LO: if (w_phase_last) w_next = SHIFT_HI;
      SHIFT_HI: begin
        if (w_phase_last) begin
          if (w_last_bit) begin
            w_next = DONE;
          end else if (w_word_end) begin
            w_next = FETCH;
          end else begin
            w_next = SHIFT_LO;
          end
        end
      end
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they are clean flop
  // outputs that line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_ready <= 1'b0;
      r_prog_clk  <= 1'b0;
      r_prog_en   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rb_valid  <= 1'b0;
      r_rb_data   <= '0;
      r_bitcnt    <= '0;
      r_wbit      <= '0;
      r_buf       <= '0;
    end else begin
      r_cfg_ready <= (w_next == FETCH);
      r_prog_clk  <= (w_next == SHIFT_HI);
      r_prog_en   <= (w_next == FETCH) || (w_next == SHIFT_LO) ||
                     (w_next == SHIFT_HI);
      r_busy      <= (w_next == FETCH) || (w_next == SHIFT_LO) ||
                     (w_next == SHIFT_HI);
      r_rb_valid  <= w_rb_emit;

      if (w_go) begin
        r_done <= 1'b0;
      end else if (w_next == DONE) begin
        r_done <= 1'b1;
      end

      if (w_go) begin
        r_bitcnt <= '0;
        r_wbit   <= '0;
      end else if (w_bit_end) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_wbit   <= w_word_end ? '0 : r_wbit + 1'b1;
      end

      // buf[0] drives prog_in, so the shift lands on the falling prog_clk
      // edge and the new bit is settled long before the next rise.
      if (w_accept) begin
        r_buf <= cfg_data;
      end else if (w_bit_end) begin
        r_buf <= r_buf >> 1;
      end

      if (w_rb_emit) begin
        r_rb_data <= r_rb_buf;
      end
    end
  end

  // Readback assembly: each sampled bit lands at its position within the
  // word, so a short final word is naturally zero-padded at the top.
  always_ff @(posedge clk) begin
    if (w_go || w_rb_emit) begin
      r_rb_buf <= '0;
    end else if (w_sample) begin
      r_rb_buf[r_wbit] <= prog_out;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign prog_in   = r_buf[0];
  assign prog_clk  = r_prog_clk;
  assign prog_en   = r_prog_en;
  assign rb_data   = r_rb_data;
  assign rb_valid  = r_rb_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
Configuration controller for the fabric's serial programming chain (connection boxes and logic elements daisy-chained via prog_in/prog_out). Accepts configuration words from a host over a valid/ready stream and serialises them LSB-first onto the chain. Generates a slow, glitch-free prog_clk and holds prog_en during the load. Captures the bits shifted out of the chain end and returns them as readback words, so the previous configuration can be checked.

Parameters:
CHAIN_LEN, 100, total programming bits in the target chain (>=1)
WORD_W, 8, host word width in bits (>=2)
CLK_DIV, 2, clk cycles per prog_clk half-period (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse that begins a load; ignored while busy
cfg_data  input  WORD_W  configuration word; bit 0 shifted first
cfg_valid  input  1  cfg_data valid
cfg_ready  output  1  loader accepts cfg_data this cycle
prog_in  output  1  serial data to chain head
prog_clk  output  1  chain shift clock, registered
prog_en  output  1  chain shift enable
prog_out  input  1  serial data returned from chain tail
rb_data  output  WORD_W  readback word, first-out bit at bit 0
rb_valid  output  1  one-cycle pulse, rb_data valid; no backpressure
busy  output  1  load in progress
done  output  1  level; last load completed; cleared by start or rst

Behaviour:
- Reset: state IDLE; cfg_ready, prog_in, prog_clk, prog_en, rb_valid, busy and done are 0; rb_data is 0; bit counter is 0. Reset mid-load aborts at once. The next cycle drives prog_en=0 and prog_clk=0. Chain contents are then undefined and the host must restart.
- IDLE: on start, go to FETCH. Next cycle: busy=1, prog_en=1, done=0, bit counter cleared.
- FETCH: cfg_ready=1 and prog_clk=0. On cfg_valid&&cfg_ready, load the word into the shift buffer and go to SHIFT_LO. If cfg_valid stays low, wait indefinitely with prog_en=1 and prog_clk=0; the chain holds its state.
- SHIFT_LO: prog_clk=0 and prog_in=buf[0], stable for the whole phase. Lasts CLK_DIV cycles. On the last cycle, sample prog_out (the bit about to leave the chain) into the readback buffer. Then go to SHIFT_HI.
- SHIFT_HI: prog_clk=1 for CLK_DIV cycles; prog_in is unchanged. On exit: increment the bit counter and shift buf right by one. Next state:
  - DONE if this was bit CHAIN_LEN-1;
  - else FETCH if this was bit WORD_W-1 of the current word;
  - else SHIFT_LO.
- prog_in changes only in the cycle prog_clk falls or earlier, never coincident with a rise.
- Cost per bit is exactly 2*CLK_DIV cycles. FETCH adds at least one cycle per word. The first prog_clk rise occurs CLK_DIV cycles after entering SHIFT_LO.
- Words: exactly ceil(CHAIN_LEN/WORD_W) words are accepted. Upper bits of the final partial word are discarded and cfg_ready stays 0 afterwards.
- Readback: rb_valid pulses for one cycle after every WORD_W sampled bits, and after the final bit. A final partial word is zero-padded in its upper bits. Number of readback words equals number of input words.
- DONE: one cycle with prog_en=0, prog_clk=0, busy=0, done=1, then back to IDLE. done stays 1 until the next start or rst.
- start while busy has no effect. start in the same cycle as rst: rst wins.
- CHAIN_LEN == WORD_W: exactly one FETCH, then DONE.

Decomposition:
- Package fpga_cfg_pkg:
  - state enum {IDLE, FETCH, SHIFT_LO, SHIFT_HI, DONE};
  - localparams NUM_WORDS = ceil(CHAIN_LEN/WORD_W), BITCNT_W = clog2(CHAIN_LEN+1), DIVCNT_W = clog2(CLK_DIV+1).
- One sub-module, cfg_phase_timer: down-counter reloaded with CLK_DIV-1 on each phase entry, asserting phase_last. Counters, FSM and shift/readback buffers stay in config_loader.

Test Plan:
1. CHAIN_LEN=12, WORD_W=8, CLK_DIV=2; start, then cfg_valid held with 0xA5, 0x0F, behavioural 12-bit shift-register model on prog_clk rise. Expect 2 handshakes, 12 prog_clk rises, model contents 0xFA5 in shift order, done=1, busy=0.
2. Same setup, model preloaded with 0xC3A. Expect rb_valid twice: rb_data=0x3A, then 0x0C (padded), matching model-out order.
3. Stall: hold cfg_valid=0 for 20 cycles after the first word. Expect prog_clk=0, prog_en=1 and no rises during the stall; the load then completes correctly.
4. Reset mid-load: assert rst during bit 5. Next cycle prog_en=0, prog_clk=0, busy=0, done=0. A fresh load then completes with correct contents.
5. start pulsed while busy and simultaneous start+rst: both ignored. Timing check: 2*CLK_DIV cycles between prog_clk rises within a word, and prog_in never toggles on a rising edge.
6. CHAIN_LEN=8, WORD_W=8, CLK_DIV=1: one word 0x81. Expect 8 rises, one rb_valid, done 17+ cycles after start.
